// File: rtl/edge_rate_meter.sv
// edge_rate_meter
//
// Counts rising and falling edge pulses over a programmable window of clock
// cycles and presents the two counts, plus a sticky saturation flag, through
// a valid/ack handshake.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   rising    in   one-cycle rising-edge pulse
//   falling   in   one-cycle falling-edge pulse
//   win_len   in   window length in cycles, sampled when a start is accepted
//   start     in   request a new measurement (ignored while running)
//   abort     in   cancel a running measurement
//   ack       in   consumer takes the presented result
//   busy      out  window running
//   valid     out  result available
//   rise_cnt  out  rising edges in the last completed window
//   fall_cnt  out  falling edges in the last completed window
//   ovf       out  a counter saturated during the last completed window
module edge_rate_meter #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rising,
  input  logic             falling,
  input  logic [WIN_W-1:0] win_len,
  input  logic             start,
  input  logic             abort,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             ovf
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           r_state;
  state_e           w_state_nxt;

  logic [WIN_W-1:0] r_timer;
  logic [CNT_W-1:0] r_rise;
  logic [CNT_W-1:0] r_fall;
  logic             r_ovf_acc;

  logic [CNT_W-1:0] r_rise_cnt;
  logic [CNT_W-1:0] r_fall_cnt;
  logic             r_ovf;

  logic             w_start_acc;
  logic             w_win_zero;
  logic             w_run_step;
  logic             w_last;
  logic             w_rise_sat;
  logic             w_fall_sat;
  logic [CNT_W-1:0] w_rise_nxt;
  logic [CNT_W-1:0] w_fall_nxt;
  logic             w_ovf_nxt;

  // Decoded control conditions shared by the FSM and datapath.
  always_comb begin
    w_start_acc = start && (r_state != StRun);
    w_win_zero  = (win_len == '0);
    // A RUN cycle that is not being aborted counts its edges.
    w_run_step  = (r_state == StRun) && !abort;
    w_last      = w_run_step && (r_timer == WIN_W'(1));
  end

  // Saturating counters; an increment attempted at full scale sets overflow.
  always_comb begin
    w_rise_sat = rising && (r_rise == CntMax);
    w_fall_sat = falling && (r_fall == CntMax);
    w_rise_nxt = (rising && !w_rise_sat) ? r_rise + CNT_W'(1) : r_rise;
    w_fall_nxt = (falling && !w_fall_sat) ? r_fall + CNT_W'(1) : r_fall;
    w_ovf_nxt  = r_ovf_acc || w_rise_sat || w_fall_sat;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic. Start wins over ack in DONE; abort wins over a
  // coinciding last-cycle completion.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt = w_win_zero ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort) begin
          w_state_nxt = StIdle;
        end else if (r_timer == WIN_W'(1)) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (start) begin
          w_state_nxt = w_win_zero ? StDone : StRun;
        end else if (ack) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM outputs and result drive.
  always_comb begin
    busy     = (r_state == StRun);
    valid    = (r_state == StDone);
    rise_cnt = r_rise_cnt;
    fall_cnt = r_fall_cnt;
    ovf      = r_ovf;
  end

  // Timer, working counters and published result. Published results only
  // change on a completed window, a zero-length start, or reset, so an abort
  // leaves the previous result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer    <= '0;
      r_rise     <= '0;
      r_fall     <= '0;
      r_ovf_acc  <= 1'b0;
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (w_start_acc) begin
      // Edges in the start cycle itself are deliberately not counted.
      r_timer   <= win_len;
      r_rise    <= '0;
      r_fall    <= '0;
      r_ovf_acc <= 1'b0;
      if (w_win_zero) begin
        r_rise_cnt <= '0;
        r_fall_cnt <= '0;
        r_ovf      <= 1'b0;
      end
    end else if (w_run_step) begin
      r_timer   <= r_timer - WIN_W'(1);
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_ovf_acc <= w_ovf_nxt;
      if (w_last) begin
        // The last cycle's edges are folded into the published counts.
        r_rise_cnt <= w_rise_nxt;
        r_fall_cnt <= w_fall_nxt;
        r_ovf      <= w_ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_edge_rate_meter.sv
module tb_edge_rate_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rising;
  logic        falling;
  logic [15:0] win_len;
  logic        start;
  logic        abort;
  logic        ack;

  logic        busy;
  logic        valid;
  logic [15:0] rise_cnt;
  logic [15:0] fall_cnt;
  logic        ovf;

  logic        busy4;
  logic        valid4;
  logic [3:0]  rise_cnt4;
  logic [3:0]  fall_cnt4;
  logic        ovf4;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  edge_rate_meter #(.CNT_W(16), .WIN_W(16)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .rising  (rising),
    .falling (falling),
    .win_len (win_len),
    .start   (start),
    .abort   (abort),
    .ack     (ack),
    .busy    (busy),
    .valid   (valid),
    .rise_cnt(rise_cnt),
    .fall_cnt(fall_cnt),
    .ovf     (ovf)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  edge_rate_meter #(.CNT_W(4), .WIN_W(16)) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .rising  (rising),
    .falling (falling),
    .win_len (win_len),
    .start   (start),
    .abort   (abort),
    .ack     (ack),
    .busy    (busy4),
    .valid   (valid4),
    .rise_cnt(rise_cnt4),
    .fall_cnt(fall_cnt4),
    .ovf     (ovf4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rising = 1'b0; falling = 1'b0; win_len = '0;
    start = 1'b0; abort = 1'b0; ack = 1'b0;
    tick; tick;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rise", rise_cnt, 0);
    check("rst_fall", fall_cnt, 0);
    rst = 1'b0;
    tick;

    // 10-cycle window, rising pulse in start cycle must be ignored.
    win_len = 16'd10; start = 1'b1; rising = 1'b1;
    tick;
    start = 1'b0; rising = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("w10_busy_%0d", k), busy, 1);
      check($sformatf("w10_valid_%0d", k), valid, 0);
      rising  = (k == 2 || k == 5 || k == 8);
      falling = (k == 3 || k == 9);
      start   = (k == 6);  // ignored while running
      tick;
    end
    rising = 1'b0; falling = 1'b0; start = 1'b0;
    check("w10_busy_end", busy, 0);
    check("w10_valid", valid, 1);
    check("w10_rise", rise_cnt, 3);
    check("w10_fall", fall_cnt, 2);
    check("w10_ovf", ovf, 0);
    check("w10_rise4", rise_cnt4, 3);
    tick;
    check("w10_hold_valid", valid, 1);
    check("w10_hold_rise", rise_cnt, 3);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    check("w10_ack_valid", valid, 0);
    check("w10_ack_rise_kept", rise_cnt, 3);

    // Saturation: rising held for 40 cycles.
    win_len = 16'd40; start = 1'b1; rising = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) tick;
    rising = 1'b0;
    check("sat_valid4", valid4, 1);
    check("sat_rise4", rise_cnt4, 15);
    check("sat_ovf4", ovf4, 1);
    check("sat_fall4", fall_cnt4, 0);
    check("sat_rise16", rise_cnt, 40);
    check("sat_ovf16", ovf, 0);
    ack = 1'b1;
    tick;
    ack = 1'b0;

    // Simultaneous rising+falling in 5 of 8 cycles.
    win_len = 16'd8; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      rising  = (k == 1 || k == 3 || k == 4 || k == 6 || k == 8);
      falling = rising;
      tick;
    end
    rising = 1'b0; falling = 1'b0;
    check("both_valid", valid, 1);
    check("both_rise", rise_cnt, 5);
    check("both_fall", fall_cnt, 5);
    check("both_ovf4_cleared", ovf4, 0);
    check("both_rise4", rise_cnt4, 5);
    ack = 1'b1;
    tick;
    ack = 1'b0;

    // Zero-length window.
    win_len = 16'd0; start = 1'b1; rising = 1'b1;
    tick;
    start = 1'b0; rising = 1'b0;
    check("w0_busy", busy, 0);
    check("w0_valid", valid, 1);
    check("w0_rise", rise_cnt, 0);
    check("w0_fall", fall_cnt, 0);
    check("w0_ovf", ovf, 0);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    check("w0_ack_valid", valid, 0);
    check("w0_busy_after", busy, 0);

    // Known result for the abort test: rise=2, fall=1.
    win_len = 16'd3; start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      rising  = (k <= 2);
      falling = (k == 3);
      tick;
    end
    rising = 1'b0; falling = 1'b0;
    check("pre_rise", rise_cnt, 2);
    check("pre_fall", fall_cnt, 1);
    ack = 1'b1; abort = 1'b1;  // abort ignored in DONE
    tick;
    ack = 1'b0; abort = 1'b0;
    check("pre_ack_valid", valid, 0);

    // Abort in cycle 4 of a 10-cycle window.
    win_len = 16'd10; start = 1'b1;
    tick;
    start = 1'b0; rising = 1'b1; falling = 1'b1;
    tick; tick; tick;
    abort = 1'b1;
    tick;
    abort = 1'b0; rising = 1'b0; falling = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_rise_kept", rise_cnt, 2);
    check("abort_fall_kept", fall_cnt, 1);
    for (int k = 0; k < 12; k++) tick;
    check("abort_valid_later", valid, 0);

    // Abort coinciding with the final window cycle.
    win_len = 16'd2; start = 1'b1;
    tick;
    start = 1'b0; rising = 1'b1;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0; rising = 1'b0;
    check("abort_last_valid", valid, 0);
    check("abort_last_busy", busy, 0);
    check("abort_last_rise", rise_cnt, 2);

    // Reset mid-run, asserted together with start.
    win_len = 16'd10; start = 1'b1;
    tick;
    start = 1'b0; rising = 1'b1;
    tick; tick; tick;
    rst = 1'b1; start = 1'b1;
    tick;
    rst = 1'b0; start = 1'b0; rising = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_rise", rise_cnt, 0);
    check("midrst_fall", fall_cnt, 0);

    // start+ack together in DONE: restart wins.
    win_len = 16'd2; start = 1'b1;
    tick;
    start = 1'b0; rising = 1'b1;
    tick;
    rising = 1'b0;
    tick;
    check("sa_pre_valid", valid, 1);
    check("sa_pre_rise", rise_cnt, 1);
    win_len = 16'd5; start = 1'b1; ack = 1'b1;
    tick;
    start = 1'b0; ack = 1'b0;
    check("sa_busy", busy, 1);
    check("sa_valid", valid, 0);
    for (int k = 0; k < 4; k++) tick;
    check("sa_busy_last", busy, 1);
    tick;
    check("sa_done_valid", valid, 1);
    check("sa_done_busy", busy, 0);
    check("sa_done_rise", rise_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
